// File: rtl/softplus_vector_unit_pkg.sv
// Shared FP32 constants, mode/state encodings and helpers for the softplus
// activation blocks (scalar unit, vector unit, neural-layer blocks).
package softplus_vector_unit_pkg;

    localparam logic [31:0] FP32_ZERO      = 32'h0000_0000;
    localparam logic [31:0] FP32_THREE     = 32'h4040_0000;
    localparam logic [31:0] FP32_MINUS_TWO = 32'hC000_0000;
    localparam logic [31:0] FP32_EXP_MASK  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        MODE_SOFTPLUS     = 2'd0,
        MODE_RELU         = 2'd1,
        MODE_IDENTITY     = 2'd2,
        MODE_SOFTPLUS_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic is_nan(input logic [31:0] x);
        return ((x & FP32_EXP_MASK) == FP32_EXP_MASK) && (x[22:0] != '0);
    endfunction

endpackage

// File: rtl/softplus_vector_unit_if.sv
// Input-vector and result-vector valid/ready channels of the vector unit.
interface softplus_vector_unit_if #(
    parameter int unsigned VLEN = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             mode;
    logic [32*VLEN-1:0]     x_vec;
    logic                   out_valid;
    logic                   out_ready;
    logic [32*VLEN-1:0]     result_vec;

    modport master (
        output in_valid, mode, x_vec, out_ready,
        input  in_ready, out_valid, result_vec
    );

    modport slave (
        input  in_valid, mode, x_vec, out_ready,
        output in_ready, out_valid, result_vec
    );
endinterface

// File: rtl/softplus_lane.sv
// Scalar combinational activation lane: softplus / ReLU / identity on one FP32 word,
// plus the FP32 compare and ln(1+e^x) approximation blocks it is built from.
module FloatingCompare (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);
    logic [31:0] ka;
    logic [31:0] kb;

    // Map to an unsigned-orderable key; +0 and -0 are forced equal.
    always_comb begin
        ka = a[31] ? ~a : {1'b1, a[30:0]};
        kb = b[31] ? ~b : {1'b1, b[30:0]};
        gt = (ka > kb) && ((a[30:0] | b[30:0]) != '0);
    end
endmodule

module LogarithmApprox (
    input  logic [31:0] x,
    output logic [31:0] y
);
    logic [7:0]         e;
    logic [23:0]        m;
    logic [20:0]        mag;
    logic signed [21:0] fx;
    logic signed [21:0] seg_s;
    logic signed [21:0] base;
    logic [2:0]         seg;
    logic [16:0]        t;
    logic [17:0]        y0;
    logic [15:0]        slope;
    logic [32:0]        prod;
    logic [17:0]        yq;
    logic [4:0]         lead;

    // Q16 fixed point, linear interpolation between integer knots on [-2, 3].
    always_comb begin
        e     = x[30:23];
        m     = {(e != 8'd0), x[22:0]};
        mag   = '0;
        if (e <= 8'd134) mag = 21'(m >> (8'd134 - e));
        fx    = x[31] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        seg_s = fx >>> 16;
        if (seg_s >= 22'sd2)       seg = 3'd4;
        else if (seg_s <= -22'sd2) seg = 3'd0;
        else                       seg = 3'(seg_s + 22'sd2);
        base  = ($signed({19'd0, seg}) - 22'sd2) <<< 16;
        t     = 17'(fx - base);
        case (seg)
            3'd0:    begin y0 = 18'd8318;   slope = 16'd12212; end
            3'd1:    begin y0 = 18'd20530;  slope = 16'd24896; end
            3'd2:    begin y0 = 18'd45426;  slope = 16'd40640; end
            3'd3:    begin y0 = 18'd86066;  slope = 16'd53324; end
            default: begin y0 = 18'd139390; slope = 16'd60402; end
        endcase
        prod = 33'(slope) * 33'(t);
        yq   = y0 + 18'(prod >> 16);
        lead = '0;
        for (int unsigned i = 0; i < 18; i++) begin
            if (yq[i]) lead = 5'(i);
        end
        y = {1'b0, 8'(8'd111 + lead), 23'({23'd0, yq} << (5'd23 - lead))};
    end
endmodule

module softplus_lane
    import softplus_vector_unit_pkg::*;
#(
    parameter logic [31:0] HI_THRESH = FP32_THREE,
    parameter logic [31:0] LO_THRESH = FP32_MINUS_TWO
) (
    input  logic [31:0] x,
    input  mode_e       mode,
    output logic [31:0] y
);
    logic        above_hi;
    logic        below_lo;
    logic [31:0] approx_y;

    FloatingCompare u_cmp_hi (.a(x),         .b(HI_THRESH), .gt(above_hi));
    FloatingCompare u_cmp_lo (.a(LO_THRESH), .b(x),         .gt(below_lo));
    LogarithmApprox u_log    (.x(x),         .y(approx_y));

    always_comb begin
        y = x;
        if (!is_nan(x)) begin
            case (mode)
                MODE_RELU:     y = (!x[31] && (x[30:0] != '0)) ? x : FP32_ZERO;
                MODE_IDENTITY: y = x;
                default:       y = above_hi ? x : (below_lo ? FP32_ZERO : approx_y);
            endcase
        end
    end
endmodule

// File: rtl/softplus_vector_unit.sv
// Vector softplus/ReLU/identity unit: latches a VLEN-word vector, streams it
// through one shared scalar lane, and presents the full result vector.
module softplus_vector_unit
    import softplus_vector_unit_pkg::*;
#(
    parameter int unsigned VLEN      = 4,
    parameter logic [31:0] HI_THRESH = FP32_THREE,
    parameter logic [31:0] LO_THRESH = FP32_MINUS_TWO
) (
    input  logic                  clk,
    input  logic                  rst,
    softplus_vector_unit_if.slave bus
);
    localparam int unsigned       IDX_W    = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VLEN - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    mode_e            mode_q;
    logic [31:0]      x_q   [VLEN];
    logic [31:0]      res_q [VLEN];
    logic [31:0]      lane_x;
    logic [31:0]      lane_y;

    softplus_lane #(
        .HI_THRESH (HI_THRESH),
        .LO_THRESH (LO_THRESH)
    ) u_lane (
        .x    (lane_x),
        .mode (mode_q),
        .y    (lane_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid && bus.in_ready) state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX)            state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)                state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) && !rst;
        bus.out_valid = (state_q == ST_DONE);
    end

    always_comb begin
        lane_x = x_q[0];
        for (int unsigned i = 0; i < VLEN; i++) begin
            if (idx_q == IDX_W'(i)) lane_x = x_q[i];
            bus.result_vec[32*i +: 32] = res_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            mode_q <= MODE_SOFTPLUS;
            for (int unsigned i = 0; i < VLEN; i++) begin
                x_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        for (int unsigned i = 0; i < VLEN; i++) x_q[i] <= bus.x_vec[32*i +: 32];
                        mode_q <= mode_e'(bus.mode);
                        idx_q  <= '0;
                    end
                end
                ST_RUN: begin
                    for (int unsigned i = 0; i < VLEN; i++) begin
                        if (idx_q == IDX_W'(i)) res_q[i] <= lane_y;
                    end
                    idx_q <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_softplus_vector_unit.sv
// Directed + randomized bench for softplus_vector_unit (VLEN=4 and VLEN=1 builds)
// against a real-arithmetic model of the activation rules.
module tb_softplus_vector_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    softplus_vector_unit_if #(.VLEN(4)) b4 ();
    softplus_vector_unit_if #(.VLEN(1)) b1 ();

    softplus_vector_unit #(.VLEN(4), .HI_THRESH(32'h40400000), .LO_THRESH(32'hC0000000)) dut4 (
        .clk (clk), .rst (rst), .bus (b4.slave)
    );
    softplus_vector_unit #(.VLEN(1), .HI_THRESH(32'h40400000), .LO_THRESH(32'hC0000000)) dut1 (
        .clk (clk), .rst (rst), .bus (b1.slave)
    );

    function automatic logic is_nan_w(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    function automatic real fp_to_real(input logic [31:0] w);
        int  e = int'(w[30:23]);
        real f = real'(w[22:0]) / 8388608.0;
        real v;
        if (e == 255)    v = 1.0e39;
        else if (e == 0) v = f * (2.0 ** (-126));
        else             v = (1.0 + f) * (2.0 ** (e - 127));
        return w[31] ? -v : v;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] picks [5] = '{32'h40400000, 32'hC0000000, 32'h00000000, 32'h80000000, 32'h3F800000};
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return {1'($urandom), 8'($urandom_range(120, 129)), 23'($urandom)};
            2:       return picks[$urandom_range(0, 4)];
            3:       return {1'($urandom), 8'h00, 23'($urandom)};
            default: return {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string tag, input logic [31:0] x, input logic [1:0] m, input logic [31:0] y);
        real  xr;
        real  yr = 0.0;
        real  ref_v;
        real  err;
        logic ok;
        if (is_nan_w(x)) check_eq(tag, y, x);
        else begin
            xr = fp_to_real(x);
            if (m == 2'd1)      check_eq(tag, y, (xr > 0.0) ? x : 32'h0);
            else if (m == 2'd2) check_eq(tag, y, x);
            else if (xr > 3.0)  check_eq(tag, y, x);
            else if (xr < -2.0) check_eq(tag, y, 32'h0);
            else begin
                ref_v = $ln(1.0 + $exp(xr));
                ok = 1'b0;
                if (y[30:23] != 8'hFF) begin
                    yr  = fp_to_real(y);
                    err = (yr > ref_v) ? yr - ref_v : ref_v - yr;
                    ok  = (err < 0.05);
                end
                n_tests++;
                assert (ok === 1'b1) else begin
                    n_fail++;
                    $error("FAIL %s observed=%h (%f) expected~%f", tag, y, yr, ref_v);
                end
            end
        end
    endtask

    task automatic check_vec4(input string tag, input logic [127:0] xv, input logic [1:0] m);
        for (int i = 0; i < 4; i++)
            check_lane($sformatf("%s[%0d]", tag, i), xv[32*i +: 32], m, b4.result_vec[32*i +: 32]);
    endtask

    // Accepts one vector on dut4 and returns cycles from accept edge to out_valid.
    task automatic issue4(input logic [127:0] xv, input logic [1:0] m, output int lat);
        int g = 0;
        b4.x_vec = xv; b4.mode = m; b4.in_valid = 1'b1;
        while (b4.in_ready !== 1'b1 && g < 20) begin tick(); g++; end
        check_eq("accept_wait", b4.in_ready, 1'b1);
        tick();
        b4.in_valid = 1'b0; b4.x_vec = ~xv; b4.mode = ~m;
        lat = 0;
        while (b4.out_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
    endtask

    task automatic release4();
        b4.out_ready = 1'b1;
        tick();
        b4.out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] xv;
        logic [127:0] xv2;
        logic [127:0] snap;
        logic [1:0]   m;
        int           lat;
        int           k;
        logic [31:0]  p_x;
        logic [1:0]   p_m;
        logic         p_valid;
        int           acc_edge;
        int           prev_acc;
        int           n_res;

        b4.in_valid = 0; b4.out_ready = 0; b4.mode = 0; b4.x_vec = '0;
        b1.in_valid = 0; b1.out_ready = 0; b1.mode = 0; b1.x_vec = '0;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_in_ready", b4.in_ready, 1'b0);
        check_eq("rst_out_valid", b4.out_valid, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", b4.in_ready, 1'b1);
        check_eq("post_rst_out_valid", b4.out_valid, 1'b0);
        check_eq("post_rst_result", b4.result_vec, 128'h0);

        // Softplus directed, with latency
        xv = {32'h40400000, 32'h00000000, 32'hC0400000, 32'h40A00000};
        issue4(xv, 2'd0, lat);
        check_eq("sp_latency", lat, 4);
        check_vec4("sp_dir", xv, 2'd0);
        release4();
        check_eq("sp_release_out_valid", b4.out_valid, 1'b0);
        check_eq("sp_release_in_ready", b4.in_ready, 1'b1);

        // ReLU directed
        xv = {32'h7FC00000, 32'h80000000, 32'h3FC00000, 32'hBFC00000};
        issue4(xv, 2'd1, lat);
        check_eq("relu_latency", lat, 4);
        check_eq("relu_dir", b4.result_vec, {32'h7FC00000, 32'h00000000, 32'h3FC00000, 32'h00000000});
        release4();

        // Identity directed, denormals included
        xv = {32'h00000001, 32'h807FFFFF, 32'h7F800000, 32'h12345678};
        issue4(xv, 2'd2, lat);
        check_eq("id_dir", b4.result_vec, xv);
        release4();

        // Reserved softplus alias at infinities, exact threshold and NaN
        xv = {32'hFF800000, 32'h7F800000, 32'hC0000000, 32'h7FC00001};
        issue4(xv, 2'd3, lat);
        check_vec4("sp_alias", xv, 2'd3);
        release4();

        // Randomized vectors
        for (int r = 0; r < 24; r++) begin
            xv = {rand_word(), rand_word(), rand_word(), rand_word()};
            m  = 2'($urandom_range(0, 3));
            issue4(xv, m, lat);
            check_eq($sformatf("rand%0d_latency", r), lat, 4);
            check_vec4($sformatf("rand%0d", r), xv, m);
            release4();
        end

        // Backpressure in DONE with in_valid held high
        xv = {rand_word(), rand_word(), rand_word(), rand_word()};
        issue4(xv, 2'd0, lat);
        snap = b4.result_vec;
        check_vec4("bp_data", xv, 2'd0);
        xv2 = {rand_word(), rand_word(), rand_word(), rand_word()};
        b4.x_vec = xv2; b4.mode = 2'd2; b4.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq($sformatf("bp_hold%0d", c), b4.result_vec, snap);
            check_eq($sformatf("bp_in_ready%0d", c), b4.in_ready, 1'b0);
            check_eq($sformatf("bp_out_valid%0d", c), b4.out_valid, 1'b1);
        end
        b4.out_ready = 1'b1;
        tick();
        b4.out_ready = 1'b0;
        check_eq("bp_idle_out_valid", b4.out_valid, 1'b0);
        check_eq("bp_idle_in_ready", b4.in_ready, 1'b1);
        tick();
        b4.in_valid = 1'b0;
        check_eq("bp_next_run_in_ready", b4.in_ready, 1'b0);
        k = 0;
        while (b4.out_valid !== 1'b1 && k < 50) begin tick(); k++; end
        check_eq("bp_next_latency", k, 4);
        check_vec4("bp_next", xv2, 2'd2);
        release4();

        // Reset in the cycle after word 1 is written
        xv = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        b4.x_vec = xv; b4.mode = 2'd2; b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        tick();
        tick();
        check_eq("mid_word1", b4.result_vec[63:32], 32'h33333333);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", b4.in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("mid_out_valid", b4.out_valid, 1'b0);
        check_eq("mid_result", b4.result_vec, 128'h0);
        check_eq("mid_in_ready", b4.in_ready, 1'b1);
        xv = {rand_word(), rand_word(), rand_word(), rand_word()};
        issue4(xv, 2'd1, lat);
        check_eq("mid_fresh_latency", lat, 4);
        check_vec4("mid_fresh", xv, 2'd1);
        release4();

        // VLEN=1 back-to-back with out_ready tied high
        b1.out_ready = 1'b1;
        b1.in_valid  = 1'b1;
        p_valid = 1'b0; p_x = '0; p_m = '0;
        acc_edge = -10; prev_acc = -1; n_res = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            b1.x_vec = rand_word();
            b1.mode  = 2'($urandom_range(0, 3));
            #1;
            if (b1.out_valid === 1'b1) begin
                check_eq($sformatf("v1_pending%0d", cyc), p_valid, 1'b1);
                check_eq($sformatf("v1_latency%0d", cyc), cyc - acc_edge, 1);
                check_lane($sformatf("v1_res%0d", cyc), p_x, p_m, b1.result_vec);
                p_valid = 1'b0;
                n_res++;
            end
            if (b1.in_valid && b1.in_ready) begin
                if (prev_acc >= 0) check_eq($sformatf("v1_period%0d", cyc), cyc + 1 - prev_acc, 3);
                acc_edge = cyc + 1;
                prev_acc = acc_edge;
                p_x = b1.x_vec; p_m = b1.mode; p_valid = 1'b1;
            end
            tick();
        end
        b1.in_valid = 1'b0;
        check_eq("v1_result_count", n_res, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
